// File: rtl/param_rr_fifo_arbiter.sv
// N_CH per-channel FIFOs merged onto one registered valid/ready output stream
// by a work-conserving round-robin arbiter. Optional drop counters: RRA_DROP_CNT_EN.
module param_rr_fifo_arbiter #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          wen,
    input  logic [N_CH*DATA_W-1:0]   din,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_chan,
    output logic [N_CH-1:0]          full,
    output logic [N_CH-1:0]          empty,
    output logic [N_CH-1:0]          overflow
`ifdef RRA_DROP_CNT_EN
    ,
    output logic [N_CH*8-1:0]        drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a word transfers on any edge where out_valid && out_ready.
    // The output register reloads whenever it is empty or being consumed.

    logic [DATA_W-1:0] mem    [N_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_CH];
    logic [PTR_W-1:0]  rd_ptr [N_CH];
    logic [CNT_W-1:0]  count  [N_CH];

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic              any_ne;
    logic              load;
    logic [N_CH-1:0]   nonempty;
    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CH) s = s - N_CH;
        return s[CH_W-1:0];
    endfunction

    assign load = !out_valid || out_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_flags
        assign nonempty[i] = (count[i] != '0);
        assign full[i]     = (count[i] == CNT_W'(DEPTH));
        assign empty[i]    = !nonempty[i];
        // Full is judged on pre-edge count, so a same-cycle pop never frees room.
        assign push[i]     = wen[i] && !full[i];
        assign pop[i]      = load && any_ne && (grant == CH_W'(i));
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        grant  = '0;
        any_ne = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!any_ne && nonempty[wrap_add(rr_ptr, k)]) begin
                grant  = wrap_add(rr_ptr, k);
                any_ne = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= din[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                if (wen[i] && full[i]) overflow[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (any_ne) begin
                out_data  <= mem[grant][rd_ptr[grant]];
                out_chan  <= grant;
                out_valid <= 1'b1;
                rr_ptr    <= wrap_add(grant, 1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RRA_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wen[i] && full[i] && drop_cnt[i*8 +: 8] != 8'hFF)
                    drop_cnt[i*8 +: 8] <= drop_cnt[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_rr_fifo_arbiter.sv
// Directed bench for param_rr_fifo_arbiter (default 4 channels x 8 bits x 8 deep).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_param_rr_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wen = '0;
    logic [31:0] din = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  overflow;
`ifdef RRA_DROP_CNT_EN
    logic [31:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    param_rr_fifo_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .din       (din),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef RRA_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wen = '0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] word(input logic [1:0] ch, input logic [7:0] d);
        return {22'd0, ch, d};
    endfunction

    initial begin
        // Reset state
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_word", word(out_chan, out_data), 32'd0);
        check("rst_empty", 32'(empty), 32'hF);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        do_reset();

        // Single write to ch2
        wen = 4'b0100;
        din = {8'h00, 8'h5A, 8'h00, 8'h00};
        out_ready = 1'b1;
        step();
        wen = '0;
        check("t1_not_fwd", 32'(out_valid), 32'd0);
        check("t1_empty_mid", 32'(empty), 32'b1011);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_word", word(out_chan, out_data), 32'h25A);
        check("t1_empty", 32'(empty), 32'hF);
        step();
        check("t1_idle", 32'(out_valid), 32'd0);

        // All four channels, two words each
        do_reset();
        wen = 4'hF;
        din = {8'h30, 8'h20, 8'h10, 8'h00};
        step();
        din = {8'h31, 8'h21, 8'h11, 8'h01};
        step();
        wen = '0;
        for (int k = 0; k < 8; k++) begin
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_word", word(out_chan, out_data),
                  word(2'(k % 4), 8'((k % 4) * 16 + k / 4)));
            out_ready = 1'b1;
            step();
        end
        check("t2_drained", 32'(out_valid), 32'd0);

        // Only ch1 and ch3 loaded: empty channels skipped
        do_reset();
        wen = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            din = {8'(8'h30 + k), 8'h00, 8'(8'h10 + k), 8'h00};
            step();
        end
        wen = '0;
        for (int k = 0; k < 6; k++) begin
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_word", word(out_chan, out_data),
                  (k % 2 == 0) ? word(2'd1, 8'(8'h10 + k / 2)) : word(2'd3, 8'(8'h30 + k / 2)));
            out_ready = 1'b1;
            step();
        end
        check("t3_drained", 32'(out_valid), 32'd0);

        // Fill ch0 while stalled: one word sits in the output register, eight in the FIFO
        do_reset();
        wen = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            din = {24'd0, 8'(8'h80 + k)};
            step();
        end
        check("t4_full", 32'(full), 32'b0001);
        check("t4_no_ovf", 32'(overflow), 32'h0);
        din = {24'd0, 8'h89};
        step();
        wen = '0;
        check("t4_ovf", 32'(overflow), 32'b0001);
        check("t4_still_full", 32'(full), 32'b0001);
        check("t4_hold_valid", 32'(out_valid), 32'd1);
        check("t4_hold_word", word(out_chan, out_data), 32'h080);
`ifdef RRA_DROP_CNT_EN
        check("t4_drop_cnt", 32'(drop_cnt[7:0]), 32'd1);
`endif

        // Full ch0: write and pop in the same cycle, write is rejected
        out_ready = 1'b1;
        wen = 4'b0001;
        din = {24'd0, 8'hEE};
        step();
        wen = '0;
        check("t5_ovf", 32'(overflow), 32'b0001);
        check("t5_not_full", 32'(full), 32'h0);
        check("t5_word", word(out_chan, out_data), 32'h081);
`ifdef RRA_DROP_CNT_EN
        check("t5_drop_cnt", 32'(drop_cnt[7:0]), 32'd2);
`endif
        for (int k = 2; k < 9; k++) begin
            step();
            check("t5_drain_valid", 32'(out_valid), 32'd1);
            check("t5_drain_word", word(out_chan, out_data), word(2'd0, 8'(8'h80 + k)));
        end
        step();
        check("t5_drained", 32'(out_valid), 32'd0);

        // Reset mid-stream between edges
        out_ready = 1'b0;
        wen = 4'b0110;
        din = {8'h00, 8'h66, 8'h55, 8'h00};
        step();
        wen = '0;
        step();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_word", word(out_chan, out_data), 32'h155);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_word", word(out_chan, out_data), 32'd0);
        check("t6_async_empty", 32'(empty), 32'hF);
        check("t6_async_ovf", 32'(overflow), 32'h0);
        step();
        rst = 1'b0;
        step();
        check("t6_post_empty", 32'(empty), 32'hF);
        check("t6_post_ovf", 32'(overflow), 32'h0);
        check("t6_post_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
